alu_cmd_sequencer: RTL and testbench

Command-side driver for the lab 4-bit-operand / 8-bit-accumulator ALU. Accepts a stream of (Data, Function) commands through a valid/ready port and buffers them in a small FIFO. Replays each sequence onto the ALU one command per cycle, starting from a cleared accumulator. On the sequence's last command it captures the accumulator and presents it on a valid/ready result port. It sits between the testbench or host logic and the ALU's Data/Function inputs, and observes the ALU's 8-bit output.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_cmd_sequencer_if.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_cmd_sequencer.sv | 107 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings and types for the ALU command sequencer.
package alu_seq_pkg;

    // ALU function encodings
    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_MUL  = 2'b01;
    localparam logic [1:0] FN_SHL  = 2'b10;
    localparam logic [1:0] FN_HOLD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

    // One queued command as stored in the FIFO
    typedef struct packed {
        logic [3:0] data;
        logic [1:0] func;
        logic       last;
    } cmd_t;

    // Operation counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and result signals of the sequencer, grouped as one bundle.
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic [1:0] cmd_func;
    logic       cmd_last;
    logic [3:0] Data;
    logic [1:0] Function;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_ops;

    // Host / ALU side
    modport master (
        output cmd_valid, cmd_data, cmd_func, cmd_last, res_ready, alu_result,
        input  cmd_ready, Data, Function, res_valid, res_data, res_ops
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_data, cmd_func, cmd_last, res_ready, alu_result,
        output cmd_ready, Data, Function, res_valid, res_data, res_ops
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO with a registered not-full (ready) flag.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic ready_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          ready_q;
    logic          push;
    logic          pop;

    // Callers never push when full or pop when empty, but guard anyway
    assign push    = push_i && ready_q;
    assign pop     = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign ready_o = ready_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Next occupancy; a push and pop together leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
    end

    // Pointers, occupancy and ready; ready follows occupancy one edge later, no bypass
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != (AW+1)'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Replays queued command sequences onto the ALU and returns each final accumulator.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               Clock,
    input  logic               Reset_b,
    alu_cmd_sequencer_if.slave bus
);

    state_e     state_q;
    logic [3:0] data_q;
    logic [1:0] func_q;
    logic       last_issued_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic [7:0] res_ops_q;

    cmd_t head;
    logic fifo_empty;
    logic fifo_ready;
    logic pop;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (Clock),
        .rst_ni  (Reset_b),
        .push_i  (bus.cmd_valid && fifo_ready),
        .pop_i   (pop),
        .wdata_i ('{data: bus.cmd_data, func: bus.cmd_func, last: bus.cmd_last}),
        .rdata_o (head),
        .ready_o (fifo_ready),
        .empty_o (fifo_empty)
    );

    // Data/Function are registered, so a command is popped on the edge that
    // starts the ISSUE cycle driving it; last_issued_q marks that cycle as final.
    assign pop = ((state_q == ST_CLEAR) || (state_q == ST_ISSUE && !last_issued_q))
                 && !fifo_empty;

    assign bus.cmd_ready = fifo_ready;
    assign bus.Data      = data_q;
    assign bus.Function  = func_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_ops   = res_ops_q;

    // Sequencer FSM with registered ALU drive and result port
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q       <= ST_IDLE;
            data_q        <= 4'd0;
            func_q        <= FN_HOLD;
            last_issued_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= 8'd0;
            res_ops_q     <= 8'd0;
        end else begin
            data_q <= 4'd0;
            func_q <= FN_HOLD;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q   <= ST_CLEAR;
                        func_q    <= FN_MUL;
                        res_ops_q <= 8'd0;
                    end
                end
                ST_CLEAR, ST_ISSUE: begin
                    if (state_q == ST_ISSUE && last_issued_q) begin
                        state_q       <= ST_CAPTURE;
                        last_issued_q <= 1'b0;
                    end else begin
                        state_q <= ST_ISSUE;
                        if (pop) begin
                            data_q        <= head.data;
                            func_q        <= head.func;
                            last_issued_q <= head.last;
                            res_ops_q     <= sat_inc8(res_ops_q);
                        end else begin
                            last_issued_q <= 1'b0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    res_data_q  <= bus.alu_result;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (!fifo_empty) begin
                            state_q   <= ST_CLEAR;
                            func_q    <= FN_MUL;
                            res_ops_q <= 8'd0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: accumulator ALU model, result scoreboard,
// table of command sequences and hand-written corner-case sequences.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus_if();

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .Clock   (clk),
        .Reset_b (rst_n),
        .bus     (bus_if)
    );

    // Lab ALU: 8-bit accumulator updated on each edge by Function
    logic [7:0] acc = 8'd0;
    always @(posedge clk) begin
        case (bus_if.Function)
            FN_ADD:  acc <= acc + {4'd0, bus_if.Data};
            FN_MUL:  acc <= {4'd0, acc[3:0]} * {4'd0, bus_if.Data};
            FN_SHL:  acc <= acc << bus_if.Data;
            default: acc <= acc;
        endcase
    end
    assign bus_if.alu_result = acc;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] ops;
    } exp_t;

    typedef struct {
        logic [3:0] data;
        logic [1:0] func;
        logic       last;
        logic [7:0] exp_res;
        logic [7:0] exp_ops;
    } vec_t;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [1:0] fn_trace[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    // One clock: at the falling edge log Function and score any result handshake
    task automatic step();
        exp_t e;
        @(negedge clk);
        fn_trace.push_back(bus_if.Function);
        if (bus_if.res_valid && bus_if.res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got res_data=%0d res_ops=%0d, expected none",
                         bus_if.res_data, bus_if.res_ops);
            end else begin
                e = sb.pop_front();
                check("res_data", bus_if.res_data, e.res);
                check("res_ops", bus_if.res_ops, e.ops);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] d, input logic [1:0] f, input logic l);
        bit done = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_data  = d;
        bus_if.cmd_func  = f;
        bus_if.cmd_last  = l;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.cmd_ready) begin
                step();
                done = 1;
                break;
            end
            step();
        end
        bus_if.cmd_valid = 1'b0;
        if (!done) fail_now("push_timeout");
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc && sb.size() != 0; i++) step();
        if (sb.size() != 0) fail_now("drain_timeout");
        repeat (3) step();
    endtask

    task automatic wait_valid(input int maxc);
        for (int i = 0; i < maxc && !bus_if.res_valid; i++) step();
        if (!bus_if.res_valid) fail_now("res_valid_timeout");
    endtask

    vec_t tbl[15];
    logic [1:0] exp_fn[5];

    initial begin
        int idx;
        bit seen;
        // Sequences: each record ends with the expected result on its last command
        tbl[0]  = '{4'd15, FN_ADD,  1'b0, 8'd0,   8'd0};
        tbl[1]  = '{4'd15, FN_MUL,  1'b1, 8'd225, 8'd2};
        tbl[2]  = '{4'd7,  FN_ADD,  1'b0, 8'd0,   8'd0};
        tbl[3]  = '{4'd3,  FN_SHL,  1'b0, 8'd0,   8'd0};
        tbl[4]  = '{4'd9,  FN_ADD,  1'b1, 8'd65,  8'd3};
        tbl[5]  = '{4'd5,  FN_HOLD, 1'b0, 8'd0,   8'd0};
        tbl[6]  = '{4'd4,  FN_ADD,  1'b1, 8'd4,   8'd2};
        tbl[7]  = '{4'd15, FN_ADD,  1'b0, 8'd0,   8'd0};
        tbl[8]  = '{4'd15, FN_MUL,  1'b0, 8'd0,   8'd0};
        tbl[9]  = '{4'd1,  FN_ADD,  1'b0, 8'd0,   8'd0};
        tbl[10] = '{4'd2,  FN_SHL,  1'b1, 8'd136, 8'd4};
        tbl[11] = '{4'd9,  FN_ADD,  1'b1, 8'd9,   8'd1};
        tbl[12] = '{4'd8,  FN_ADD,  1'b0, 8'd0,   8'd0};
        tbl[13] = '{4'd8,  FN_MUL,  1'b0, 8'd0,   8'd0};
        tbl[14] = '{4'd0,  FN_HOLD, 1'b1, 8'd64,  8'd3};
        exp_fn = '{FN_MUL, FN_ADD, FN_MUL, FN_SHL, FN_HOLD};

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_data  = 4'd0;
        bus_if.cmd_func  = FN_ADD;
        bus_if.cmd_last  = 1'b0;
        bus_if.res_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus_if.cmd_ready, 1);
        check("rst_data", bus_if.Data, 0);
        check("rst_function", bus_if.Function, FN_HOLD);
        check("rst_res_valid", bus_if.res_valid, 0);
        check("rst_res_data", bus_if.res_data, 0);
        check("rst_res_ops", bus_if.res_ops, 0);
        rst_n = 1'b1;
        step();

        // Basic sequence and its Function trace
        fn_trace.delete();
        push_cmd(4'd3, FN_ADD, 1'b0);
        push_cmd(4'd2, FN_MUL, 1'b0);
        sb.push_back('{8'd12, 8'd3});
        push_cmd(4'd1, FN_SHL, 1'b1);
        wait_drain(50);
        idx = -1;
        for (int i = 0; i < fn_trace.size(); i++) begin
            if (fn_trace[i] == FN_MUL) begin
                idx = i;
                break;
            end
        end
        if (idx < 0 || idx + 5 > fn_trace.size()) begin
            fail_now("basic_fn_trace");
        end else begin
            for (int i = 0; i < 5; i++) check("basic_function", fn_trace[idx+i], exp_fn[i]);
        end

        // Table-driven sequences
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].last) sb.push_back('{tbl[i].exp_res, tbl[i].exp_ops});
            push_cmd(tbl[i].data, tbl[i].func, tbl[i].last);
        end
        wait_drain(100);

        // Starvation stall: accumulator preserved while the FIFO is empty
        push_cmd(4'd5, FN_ADD, 1'b0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.Function == FN_ADD) begin
                seen = 1;
                break;
            end
            step();
        end
        if (!seen) fail_now("stall_issue");
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_function", bus_if.Function, FN_HOLD);
            check("stall_acc", bus_if.alu_result, 5);
        end
        sb.push_back('{8'd5, 8'd2});
        push_cmd(4'd0, FN_ADD, 1'b1);
        wait_drain(50);

        // Result backpressure with two queued sequences
        bus_if.res_ready = 1'b0;
        sb.push_back('{8'd12, 8'd2});
        sb.push_back('{8'd18, 8'd2});
        push_cmd(4'd3, FN_ADD, 1'b0);
        push_cmd(4'd4, FN_MUL, 1'b1);
        push_cmd(4'd9, FN_ADD, 1'b0);
        push_cmd(4'd1, FN_SHL, 1'b1);
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            check("bp_res_data", bus_if.res_data, 12);
            check("bp_res_valid", bus_if.res_valid, 1);
            check("bp_function", bus_if.Function, FN_HOLD);
            step();
        end
        bus_if.res_ready = 1'b1;
        step();
        check("bp_clear_after_hs", bus_if.Function, FN_MUL);
        check("bp_valid_dropped", bus_if.res_valid, 0);
        wait_drain(50);

        // Fill to full while the result port is back-pressured
        bus_if.res_ready = 1'b0;
        sb.push_back('{8'd1, 8'd1});
        push_cmd(4'd1, FN_ADD, 1'b1);
        wait_valid(50);
        for (int i = 0; i < 4; i++) push_cmd(4'd1, FN_ADD, 1'b0);
        check("full_ready_low", bus_if.cmd_ready, 0);
        sb.push_back('{8'd6, 8'd5});
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_data  = 4'd2;
        bus_if.cmd_func  = FN_ADD;
        bus_if.cmd_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("full_held", bus_if.cmd_ready, 0);
            step();
        end
        bus_if.res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.Function == FN_ADD) begin
                check("ready_after_pop", bus_if.cmd_ready, 1);
                step();
                seen = 1;
                break;
            end
            check("ready_while_full", bus_if.cmd_ready, 0);
            step();
        end
        bus_if.cmd_valid = 1'b0;
        if (!seen) fail_now("fifth_push");
        wait_drain(50);

        // Saturating op count with no-op commands
        sb.push_back('{8'd0, 8'd255});
        for (int i = 0; i < 300; i++) push_cmd(4'd0, FN_HOLD, (i == 299));
        wait_drain(400);

        // Asynchronous reset mid-sequence with a pending result and 3 queued entries
        bus_if.res_ready = 1'b0;
        sb.push_back('{8'd1, 8'd1});
        push_cmd(4'd1, FN_ADD, 1'b1);
        wait_valid(50);
        for (int i = 0; i < 3; i++) push_cmd(4'd2, FN_ADD, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", bus_if.cmd_ready, 1);
        check("arst_data", bus_if.Data, 0);
        check("arst_function", bus_if.Function, FN_HOLD);
        check("arst_res_valid", bus_if.res_valid, 0);
        check("arst_res_data", bus_if.res_data, 0);
        check("arst_res_ops", bus_if.res_ops, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_if.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_no_result", bus_if.res_valid, 0);
            check("post_rst_function", bus_if.Function, FN_HOLD);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
